// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS data-memory/IO block: IO register map, TX FIFO depth,
// STATUS field positions and the address-to-target decode helper.
package mips_io_pkg;

    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_000C;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    localparam int ST_IRQ      = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_COUNT_LO = 3;
    localparam int ST_OVF      = 6;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_TIMER,
        SEL_STATUS,
        SEL_TXDATA
    } sel_e;

    // IO registers only; the RAM window depends on RAM_WORDS and is decoded by the top.
    function automatic sel_e io_decode(input logic [29:0] word_addr);
        sel_e sel;
        sel = SEL_NONE;
        if (word_addr == ADDR_CYCLE[31:2])  sel = SEL_CYCLE;
        if (word_addr == ADDR_TIMER[31:2])  sel = SEL_TIMER;
        if (word_addr == ADDR_STATUS[31:2]) sel = SEL_STATUS;
        if (word_addr == ADDR_TXDATA[31:2]) sel = SEL_TXDATA;
        return sel;
    endfunction

endpackage

// File: rtl/mips_dmem_io_tx_fifo.sv
// Small synchronous FIFO for the TX byte stream; a push into a full FIFO is dropped
// and flagged on drop for that cycle, regardless of a same-cycle pop.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [WIDTH-1:0]               head,
    output logic                           drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        drop     = push && full;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mips_dmem_io.sv
// Data-memory side of a small MIPS core: word RAM plus memory-mapped CYCLE counter,
// down-counting TIMER with irq, STATUS (W1C) and a TX byte FIFO.
module mips_dmem_io
    import mips_io_pkg::*;
#(
    parameter int RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]        ram_q [RAM_WORDS];
    logic [31:0]        cycle_q, cycle_d;
    logic [31:0]        timer_q, timer_d;
    logic               irq_q, irq_d;
    logic               ovf_q, ovf_d;

    sel_e               sel;
    logic [RAM_AW-1:0]  ram_idx;
    logic               we, ram_we, timer_wr, status_wr, fifo_push, fifo_pop, irq_set;
    logic               fifo_full, fifo_empty, fifo_drop;
    logic [FIFO_CW-1:0] fifo_count;
    logic [31:0]        status_rd;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, aluout[1:0]};
    assign ram_idx          = aluout[RAM_AW+1:2];
    assign we               = memwrite && !reset;

    always_comb begin
        sel = io_decode(aluout[31:2]);
        if (aluout[31:2] < 30'(RAM_WORDS)) sel = SEL_RAM;
    end

    assign ram_we    = we && (sel == SEL_RAM);
    assign timer_wr  = we && (sel == SEL_TIMER);
    assign status_wr = we && (sel == SEL_STATUS);
    assign fifo_push = we && (sel == SEL_TXDATA);
    assign fifo_pop  = tx_valid && tx_ready && !reset;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (writedata[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (tx_data),
        .drop      (fifo_drop)
    );

    assign tx_valid  = !fifo_empty;
    assign timer_irq = irq_q;

    // A set in the same cycle as a W1C write always wins over the clear.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        timer_d = timer_q;
        irq_set = 1'b0;
        if (timer_wr) begin
            timer_d = writedata;
        end else if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
            irq_set = (timer_q == 32'd1);
        end
        irq_d = irq_q;
        if (status_wr && writedata[ST_IRQ]) irq_d = 1'b0;
        if (irq_set) irq_d = 1'b1;
        ovf_d = ovf_q;
        if (status_wr && writedata[ST_OVF]) ovf_d = 1'b0;
        if (fifo_drop) ovf_d = 1'b1;
    end

    always_comb begin
        status_rd                         = '0;
        status_rd[ST_IRQ]                 = irq_q;
        status_rd[ST_FULL]                = fifo_full;
        status_rd[ST_EMPTY]               = fifo_empty;
        status_rd[ST_COUNT_LO +: FIFO_CW] = fifo_count;
        status_rd[ST_OVF]                 = ovf_q;
    end

    always_comb begin
        readdata = '0;
        case (sel)
            SEL_RAM:    readdata = ram_q[ram_idx];
            SEL_CYCLE:  readdata = cycle_q;
            SEL_TIMER:  readdata = timer_q;
            SEL_STATUS: readdata = status_rd;
            default:    readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            timer_q <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            timer_q <= timer_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= writedata;
    end

endmodule

// File: tb/tb_mips_dmem_io.sv
// Self-checking bench for mips_dmem_io: load results and TX bytes are predicted into
// scoreboard queues at stimulus time and popped when the DUT presents them.
module tb_mips_dmem_io;
    import mips_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        timer_irq;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] rd_sb[$];
    logic [7:0]  tx_sb[$];
    bit          m_ovf   = 1'b0;

    always #5 clk = ~clk;

    mips_dmem_io #(.RAM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status(input bit irq);
        logic [31:0] s;
        int          n;
        n    = tx_sb.size();
        s    = '0;
        s[0] = irq;
        s[1] = (n == 4);
        s[2] = (n == 0);
        s[5:3] = 3'(n);
        s[6] = m_ovf;
        return s;
    endfunction

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        if (a == ADDR_TXDATA) begin
            if (tx_sb.size() >= 4) m_ovf = 1'b1;
            else tx_sb.push_back(d[7:0]);
        end
        if (a == ADDR_STATUS && d[6]) m_ovf = 1'b0;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 1'b0;
        aluout   = a;
        rd_sb.push_back(exp);
        #1;
        chk(tag, readdata, rd_sb.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < 12 && tx_sb.size() != 0; i++) @(negedge clk);
        idle(1);
        tx_ready = 1'b0;
        chk({tag, "_left"}, tx_sb.size(), 0);
        chk({tag, "_valid"}, {31'b0, tx_valid}, 32'd0);
    endtask

    // Handshake monitor: samples just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (tx_valid && tx_ready && !reset) begin
            if (tx_sb.size() == 0) chk("tx_unexpected_pop", tx_sb.size(), 1);
            else chk("tx_data", {24'b0, tx_data}, {24'b0, tx_sb.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; memwrite = 1'b0; aluout = '0; writedata = '0; tx_ready = 1'b0;
        idle(2);
        rd("rst_cycle", ADDR_CYCLE, 32'd0);
        reset = 1'b0;
        rd("rst_status", ADDR_STATUS, 32'h0000_0004);
        rd("rst_timer", ADDR_TIMER, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_irq", {31'b0, timer_irq}, 32'd0);

        // RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
        rd("ram_unmapped", 32'h0000_0200, 32'd0);
        rd("ram_past_end", 32'h0000_0100, 32'd0);
        wr(32'h0000_00FC, 32'hCAFE_F00D);
        rd("ram_top", 32'h0000_00FC, 32'hCAFE_F00D);
        memwrite = 1'b1; aluout = 32'h0000_0010; writedata = 32'h1234_5678;
        rd_sb.push_back(32'hDEAD_BEEF);
        #1;
        chk("ram_old_data", readdata, rd_sb.pop_front());
        @(negedge clk);
        memwrite = 1'b0;
        rd("ram_new_data", 32'h0000_0010, 32'h1234_5678);
        wr(32'hFFFF_0010, 32'h5555_AAAA);
        rd("unmapped_wr", 32'hFFFF_0010, 32'd0);
        rd("txdata_rd", ADDR_TXDATA, 32'd0);

        // TIMER / irq
        wr(ADDR_TIMER, 32'd3);
        rd("tmr_load", ADDR_TIMER, 32'd3);
        chk("irq_t0", {31'b0, timer_irq}, 32'd0);
        idle(2);
        rd("tmr_at1", ADDR_TIMER, 32'd1);
        chk("irq_t2", {31'b0, timer_irq}, 32'd0);
        idle(1);
        chk("irq_rise", {31'b0, timer_irq}, 32'd1);
        rd("tmr_zero", ADDR_TIMER, 32'd0);
        rd("status_irq", ADDR_STATUS, model_status(1'b1));
        idle(2);
        rd("tmr_hold0", ADDR_TIMER, 32'd0);
        wr(ADDR_STATUS, 32'h0000_0001);
        chk("irq_clear", {31'b0, timer_irq}, 32'd0);
        wr(ADDR_TIMER, 32'd2);
        idle(1);
        rd("tmr_pre_rewrite", ADDR_TIMER, 32'd1);
        wr(ADDR_TIMER, 32'd5);
        chk("irq_rewrite_wins", {31'b0, timer_irq}, 32'd0);
        rd("tmr_rewritten", ADDR_TIMER, 32'd5);
        idle(4);
        chk("irq_rewrite_t4", {31'b0, timer_irq}, 32'd0);
        idle(1);
        chk("irq_rewrite_rise", {31'b0, timer_irq}, 32'd1);
        wr(ADDR_STATUS, 32'h0000_0001);

        // FIFO fill past full
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) wr(ADDR_TXDATA, 32'(i * 8'h11));
        rd("fifo_full_status", ADDR_STATUS, 32'h0000_0062);
        rd("fifo_model_status", ADDR_STATUS, model_status(1'b0));
        chk("tx_head", {24'b0, tx_data}, 32'h11);
        idle(2);
        chk("tx_head_stable", {24'b0, tx_data}, 32'h11);
        drain("fill_drain");
        rd("ovf_sticky", ADDR_STATUS, 32'h0000_0044);
        wr(ADDR_STATUS, 32'h0000_0040);
        rd("ovf_clear", ADDR_STATUS, 32'h0000_0004);

        // Simultaneous push/pop at count 2
        wr(ADDR_TXDATA, 32'h0000_00A1);
        wr(ADDR_TXDATA, 32'h0000_00B2);
        rd("pp_count2", ADDR_STATUS, 32'h0000_0010);
        tx_ready = 1'b1;
        wr(ADDR_TXDATA, 32'h0000_00C3);
        tx_ready = 1'b0;
        rd("pp_count_hold", ADDR_STATUS, model_status(1'b0));
        chk("pp_head", {24'b0, tx_data}, 32'hB2);
        drain("pp_drain");

        // Reset mid-countdown with FIFO count 3; RAM store during reset is ignored
        wr(ADDR_TIMER, 32'd10);
        for (int i = 0; i < 3; i++) wr(ADDR_TXDATA, 32'(8'h70 + i));
        rd("pre_rst_status", ADDR_STATUS, 32'h0000_0018);
        reset = 1'b1; tx_ready = 1'b1;
        memwrite = 1'b1; aluout = 32'h0000_0010; writedata = 32'hBAD0_BAD0;
        tx_sb.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0; tx_ready = 1'b0; memwrite = 1'b0;
        rd("mid_rst_timer", ADDR_TIMER, 32'd0);
        rd("mid_rst_cycle", ADDR_CYCLE, 32'd0);
        chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("mid_rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("mid_rst_irq", {31'b0, timer_irq}, 32'd0);
        rd("rst_ram_kept", 32'h0000_0010, 32'h1234_5678);
        idle(5);
        rd("cycle_after5", ADDR_CYCLE, 32'd5);

        // CYCLE wrap
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        rd("cycle_forced", ADDR_CYCLE, 32'hFFFF_FFFE);
        idle(1);
        rd("cycle_max", ADDR_CYCLE, 32'hFFFF_FFFF);
        idle(1);
        rd("cycle_wrap", ADDR_CYCLE, 32'd0);

        idle(1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_dmem_io.md
MIPS_DMEM_IO -- requirements
Module: mips_dmem_io

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named as listed below.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: memwrite  input  1  the processor's store strobe for the current cycle.
REQ-005 Port: aluout  input  32  byte address from the processor; word-aligned, so bits [1:0] are ignored.
REQ-006 Port: writedata  input  32  store data.
REQ-007 Port: readdata  output  32  load data; combinational from aluout and current state.
REQ-008 Port: tx_valid  output  1  the TX FIFO head is valid.
REQ-009 Port: tx_data  output  8  the TX FIFO head byte.
REQ-010 Port: tx_ready  input  1  the consumer accepts the head when tx_valid and tx_ready are both high at the rising edge.
REQ-011 Port: timer_irq  output  1  equals the STATUS.irq flag.
REQ-012 Parameter: RAM_WORDS, default 64, number of RAM words.

Function
REQ-013 Address decode SHALL be as follows:
- 0x0000_0000 to 4*RAM_WORDS-4: RAM; index = aluout[7:2].
- 0xFFFF_0000: CYCLE, read-only.
- 0xFFFF_0004: TIMER, read/write.
- 0xFFFF_0008: STATUS, read and write-1-to-clear.
- 0xFFFF_000C: TXDATA, write-only.
REQ-014 Any unmapped address SHALL read 0x0000_0000, and writes to it SHALL have no effect.
REQ-015 RAM SHALL be read combinationally (zero latency) and written at the rising edge when memwrite=1; a same-cycle read returns the old word.
REQ-016 CYCLE SHALL increment by 1 every cycle, wrap from 0xFFFF_FFFF to 0, and ignore writes.
REQ-017 A TIMER write SHALL load writedata; otherwise TIMER SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-018 The irq flag SHALL be set in the cycle in which TIMER decrements from 1 to 0; a TIMER write in that same cycle SHALL win, with no set.
REQ-019 STATUS read fields SHALL be:
- bit0: irq.
- bit1: fifo_full.
- bit2: fifo_empty.
- bits[5:3]: fifo_count (0-4).
- bit6: overflow (sticky).
- all other bits: 0.
REQ-020 A STATUS write SHALL clear irq if writedata[0]=1 and overflow if writedata[6]=1; a set in the same cycle SHALL win over a clear.
REQ-021 A TXDATA write SHALL push writedata[7:0] into a 4-deep FIFO.
REQ-022 If the FIFO is full at the start of the cycle, the push SHALL be dropped and overflow set, even if a pop occurs in the same cycle.
REQ-023 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged and preserve order.
REQ-024 tx_valid SHALL equal !fifo_empty; tx_data SHALL be the oldest entry and SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-025 TXDATA SHALL read as 0.
REQ-026 Read-side values SHALL reflect pre-edge state; a store becomes visible to loads on the next cycle.

Reset
REQ-027 While reset=1 at an edge, CYCLE, TIMER, irq, overflow and FIFO pointers/count SHALL clear to 0 (FIFO empty), giving tx_valid=0, tx_data=0 and timer_irq=0.
REQ-028 RAM contents SHALL NOT be reset.
REQ-029 memwrite SHALL be ignored while reset=1.
REQ-030 A reset asserted mid-countdown or with a non-empty FIFO SHALL discard pending state; no tx handshake completes in that cycle.

Structure
REQ-031 A shared package mips_io_pkg SHALL hold the address constants, FIFO depth (4), and STATUS bit positions.
REQ-032 The FIFO SHALL be a sub-module tx_fifo, parameterised width 8 and depth 4, with push, pop, full, empty, count and overflow-drop behaviour.
REQ-033 Decode, RAM, CYCLE, TIMER and STATUS logic SHALL reside in mips_dmem_io.

Verification
REQ-034 RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> readdata=0xDEADBEEF next cycle; load 0x0000_0200 -> 0.
REQ-035 Timer: write TIMER=3 -> timer_irq rises exactly 3 cycles later; write STATUS=0x1 -> timer_irq=0 next cycle; rewrite TIMER on the 1->0 cycle -> no irq.
REQ-036 FIFO: tx_ready=0, write TXDATA 0x11,0x22,0x33,0x44,0x55 -> STATUS=0x62 (full, count 4, overflow); raise tx_ready -> tx_data sequence 11,22,33,44, then tx_valid=0.
REQ-037 Simultaneous push/pop with count 2 -> count stays 2 and order is preserved.
REQ-038 Reset: assert reset mid-countdown with FIFO count 3 -> TIMER=0, tx_valid=0, CYCLE=0; CYCLE reads 5 after 5 post-reset cycles.
REQ-039 Wrap: force CYCLE near 0xFFFF_FFFF (via bench hierarchy) -> next value is 0.
